// File: rtl/mem_bus_pkg.sv
// Shared types and default widths for initiators on the synchronous memory port.
package mem_bus_pkg;

    localparam int unsigned MEM_ADDR_W = 16;
    localparam int unsigned MEM_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } mover_state_t;

    typedef enum logic {
        COPY = 1'b0,
        FILL = 1'b1
    } mover_mode_t;

endpackage

// File: rtl/mem_block_mover.sv
// Block copy/fill initiator on the single-port synchronous memory bus.
// Copy alternates READ/WRITE per byte; fill issues back-to-back WRITEs.
module mem_block_mover
    import mem_bus_pkg::*;
#(
    parameter int unsigned ADDR_W = MEM_ADDR_W,
    parameter int unsigned DATA_W = MEM_DATA_W
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR_W-1:0] src,
    input  logic [ADDR_W-1:0] dst,
    input  logic [ADDR_W-1:0] len,
    input  logic [DATA_W-1:0] fill_val,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] count,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    mover_state_t      state_q;
    mover_mode_t       mode_q;
    logic [ADDR_W-1:0] src_q;
    logic [ADDR_W-1:0] dst_q;
    logic [ADDR_W-1:0] rem_q;
    logic [ADDR_W-1:0] count_q;
    logic [DATA_W-1:0] fill_q;
    logic              busy_q;
    logic              done_q;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= IDLE;
            mode_q  <= COPY;
            src_q   <= '0;
            dst_q   <= '0;
            rem_q   <= '0;
            count_q <= '0;
            fill_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        mode_q  <= mover_mode_t'(mode);
                        src_q   <= src;
                        dst_q   <= dst;
                        rem_q   <= len;
                        fill_q  <= fill_val;
                        count_q <= '0;
                        if (len == '0) begin
                            done_q <= 1'b1;
                        end else if (mover_mode_t'(mode) == FILL) begin
                            state_q <= WRITE;
                            busy_q  <= 1'b1;
                        end else begin
                            state_q <= READ;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (abort) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q <= WRITE;
                    end
                end
                WRITE: begin
                    // Abort drops the bookkeeping for the write already on the bus.
                    if (abort) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        src_q   <= src_q + ADDR_W'(1);
                        dst_q   <= dst_q + ADDR_W'(1);
                        count_q <= count_q + ADDR_W'(1);
                        rem_q   <= rem_q - ADDR_W'(1);
                        if (rem_q == ADDR_W'(1)) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else if (mode_q == COPY) begin
                            state_q <= READ;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Copy data passes straight from the read port; the memory holds it until the next read.
    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        unique case (state_q)
            READ: begin
                mem_addr = src_q;
            end
            WRITE: begin
                mem_addr  = dst_q;
                mem_we    = 1'b1;
                mem_wdata = (mode_q == FILL) ? fill_q : mem_rdata;
            end
            default: begin
                mem_addr  = '0;
            end
        endcase
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign count = count_q;

endmodule

// File: tb/tb_mem_block_mover.sv
// Directed bench for mem_block_mover paired with a 64 KiB synchronous test memory.
module tb_mem_block_mover;

    logic        clk;
    logic        rst_b;
    logic        start;
    logic        mode;
    logic [15:0] src;
    logic [15:0] dst;
    logic [15:0] len;
    logic [7:0]  fill_val;
    logic        abort;
    logic        busy;
    logic        done;
    logic [15:0] count;
    logic [15:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

    logic [7:0]  mem [0:65535];
    logic        tb_clr;
    logic        tb_we;
    logic [15:0] tb_addr;
    logic [7:0]  tb_wdata;

    int checks;
    int failures;

    mem_block_mover #(
        .ADDR_W (16),
        .DATA_W (8)
    ) dut (
        .clk       (clk),
        .rst_b     (rst_b),
        .start     (start),
        .mode      (mode),
        .src       (src),
        .dst       (dst),
        .len       (len),
        .fill_val  (fill_val),
        .abort     (abort),
        .busy      (busy),
        .done      (done),
        .count     (count),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Test memory: registered read, read data held across write cycles; bench preload port.
    always @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            mem_rdata <= '0;
        end else if (tb_clr) begin
            for (int i = 0; i < 65536; i++) mem[i] <= 8'hFF;
        end else if (tb_we) begin
            mem[tb_addr] <= tb_wdata;
        end else if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end else begin
            mem_rdata <= mem[mem_addr];
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic mem_poke(input logic [15:0] a, input logic [7:0] d);
        @(negedge clk);
        tb_we = 1'b1; tb_addr = a; tb_wdata = d;
        @(negedge clk);
        tb_we = 1'b0;
    endtask

    // Returns at the negedge of the done cycle (or after the post-abort window).
    task automatic xfer(input bit no_wait, input logic m, input logic [15:0] s, input logic [15:0] d,
                        input logic [15:0] l, input logic [7:0] fv, input int abort_at, input int poke_at,
                        output int done_cyc, output int writes, output int busy_cyc);
        if (!no_wait) @(negedge clk);
        mode = m; src = s; dst = d; len = l; fill_val = fv; start = 1'b1;
        done_cyc = 0; writes = 0; busy_cyc = 0;
        for (int k = 1; k <= 64; k++) begin
            @(negedge clk);
            start = 1'b0;
            abort = 1'b0;
            if (mem_we) writes++;
            if (busy) busy_cyc++;
            if (done && done_cyc == 0) done_cyc = k;
            if (k == abort_at) abort = 1'b1;
            if (k == poke_at) begin
                start = 1'b1; mode = ~m; src = 16'h0000; dst = 16'h3000;
                len = 16'h0009; fill_val = 8'h77;
            end
            if (done_cyc != 0) break;
            if (abort_at != 0 && k > abort_at + 3) break;
        end
    endtask

    int dc, wr, bc;

    initial begin
        checks = 0; failures = 0;
        rst_b = 1'b0; start = 1'b0; mode = 1'b0; src = '0; dst = '0; len = '0;
        fill_val = '0; abort = 1'b0; tb_clr = 1'b0; tb_we = 1'b0; tb_addr = '0; tb_wdata = '0;

        #12;
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_count", count, 0);
        check_eq("rst_we", mem_we, 0);
        check_eq("rst_addr", mem_addr, 0);
        check_eq("rst_wdata", mem_wdata, 0);
        @(negedge clk); rst_b = 1'b1;

        @(negedge clk); tb_clr = 1'b1;
        @(negedge clk); tb_clr = 1'b0;
        mem_poke(16'h1000, 8'h11);
        mem_poke(16'h1001, 8'h22);
        mem_poke(16'h1002, 8'h33);
        mem_poke(16'h0010, 8'hAA);

        // Fill 4 bytes at 0x0200.
        xfer(0, 1'b1, 16'h0000, 16'h0200, 16'd4, 8'h5A, 0, 0, dc, wr, bc);
        check_eq("fill_done_cyc", dc, 5);
        check_eq("fill_writes", wr, 4);
        check_eq("fill_busy_cyc", bc, 4);
        check_eq("fill_busy_in_done", busy, 0);
        check_eq("fill_count", count, 4);
        for (int i = 0; i < 4; i++) check_eq("fill_data", mem[16'h0200 + i], 8'h5A);
        check_eq("fill_past_end", mem[16'h0204], 8'hFF);

        // Copy started in the fill's done cycle.
        xfer(1, 1'b0, 16'h1000, 16'h2000, 16'd3, 8'h00, 0, 0, dc, wr, bc);
        check_eq("copy_done_cyc", dc, 7);
        check_eq("copy_writes", wr, 3);
        check_eq("copy_busy_cyc", bc, 6);
        check_eq("copy_count", count, 3);
        check_eq("copy_d0", mem[16'h2000], 8'h11);
        check_eq("copy_d1", mem[16'h2001], 8'h22);
        check_eq("copy_d2", mem[16'h2002], 8'h33);
        @(negedge clk);
        check_eq("done_one_cycle", done, 0);

        // Forward overlapping copy propagates the first byte.
        xfer(0, 1'b0, 16'h0010, 16'h0011, 16'd4, 8'h00, 0, 0, dc, wr, bc);
        check_eq("ovl_done_cyc", dc, 9);
        for (int i = 1; i <= 4; i++) check_eq("ovl_data", mem[16'h0010 + i], 8'hAA);
        check_eq("ovl_past_end", mem[16'h0015], 8'hFF);

        // Fill across the address wrap.
        xfer(0, 1'b1, 16'h0000, 16'hFFFE, 16'd4, 8'h3C, 0, 0, dc, wr, bc);
        check_eq("wrap_writes", wr, 4);
        check_eq("wrap_fffe", mem[16'hFFFE], 8'h3C);
        check_eq("wrap_ffff", mem[16'hFFFF], 8'h3C);
        check_eq("wrap_0000", mem[16'h0000], 8'h3C);
        check_eq("wrap_0001", mem[16'h0001], 8'h3C);
        check_eq("wrap_0002", mem[16'h0002], 8'hFF);

        // Zero length.
        xfer(0, 1'b1, 16'h0000, 16'h0300, 16'd0, 8'h99, 0, 0, dc, wr, bc);
        check_eq("len0_done_cyc", dc, 1);
        check_eq("len0_writes", wr, 0);
        check_eq("len0_busy_cyc", bc, 0);
        check_eq("len0_count", count, 0);
        check_eq("len0_mem", mem[16'h0300], 8'hFF);

        // start while busy is ignored.
        xfer(0, 1'b0, 16'h1000, 16'h2100, 16'd3, 8'h00, 0, 3, dc, wr, bc);
        check_eq("poke_done_cyc", dc, 7);
        check_eq("poke_writes", wr, 3);
        check_eq("poke_count", count, 3);
        check_eq("poke_d0", mem[16'h2100], 8'h11);
        check_eq("poke_d2", mem[16'h2102], 8'h33);
        check_eq("poke_no_fill", mem[16'h3000], 8'hFF);

        // Abort during the second WRITE of an 8-byte fill.
        xfer(0, 1'b1, 16'h0000, 16'h4000, 16'd8, 8'hE1, 2, 0, dc, wr, bc);
        check_eq("abort_no_done", dc, 0);
        check_eq("abort_writes", wr, 2);
        check_eq("abort_busy_cyc", bc, 2);
        check_eq("abort_count", count, 1);
        check_eq("abort_d1", mem[16'h4001], 8'hE1);
        check_eq("abort_d2", mem[16'h4002], 8'hFF);

        // Asynchronous reset in the middle of a copy.
        @(negedge clk);
        mode = 1'b0; src = 16'h1000; dst = 16'h5000; len = 16'd3; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check_eq("pre_rst_we", mem_we, 1);
        check_eq("pre_rst_count", count, 1);
        #1 rst_b = 1'b0;
        #1;
        check_eq("arst_we", mem_we, 0);
        check_eq("arst_addr", mem_addr, 0);
        check_eq("arst_busy", busy, 0);
        check_eq("arst_count", count, 0);
        @(negedge clk);
        check_eq("arst_d0", mem[16'h5000], 8'h11);
        check_eq("arst_d1", mem[16'h5001], 8'hFF);
        rst_b = 1'b1;

        xfer(0, 1'b0, 16'h1000, 16'h5000, 16'd3, 8'h00, 0, 0, dc, wr, bc);
        check_eq("post_rst_done_cyc", dc, 7);
        check_eq("post_rst_count", count, 3);
        check_eq("post_rst_d1", mem[16'h5001], 8'h22);
        check_eq("post_rst_d2", mem[16'h5002], 8'h33);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_block_mover.md
# mem_block_mover

Bus initiator that copies or fills a block of bytes on the 16-bit-address, 8-bit-data synchronous memory port. It drives the same single-port memory interface the test memories and RAM respond to: one access per cycle, write on `we`, registered read data one edge after the address. It sits between control logic (CPU-mapped registers or a bench sequencer) and the memory. It replaces CPU byte loops for RAM clears and block moves.

## Interface
- `ADDR_W`, default 16: memory address width; all address arithmetic is modulo 2^ADDR_W.
- `DATA_W`, default 8: memory data width.
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst_b`  in  1  reset, asynchronous, active-low.
- `start`  in  1  request a transfer; sampled only in IDLE.
- `mode`  in  1  0 = copy, 1 = fill; latched with `start`.
- `src`  in  ADDR_W  copy source base; latched with `start`; ignored in fill.
- `dst`  in  ADDR_W  destination base; latched with `start`.
- `len`  in  ADDR_W  byte count; 0 = no transfer.
- `fill_val`  in  DATA_W  fill byte; latched with `start`.
- `abort`  in  1  cancel the transfer in progress.
- `busy`  out  1  transfer in progress.
- `done`  out  1  one-cycle pulse on normal completion.
- `count`  out  ADDR_W  bytes written so far in the current or last transfer.
- `mem_addr`  out  ADDR_W  memory address.
- `mem_we`  out  1  memory write enable.
- `mem_wdata`  out  DATA_W  memory write data.
- `mem_rdata`  in  DATA_W  memory read data, valid one edge after a read address.

## Operation
- States: IDLE, READ, WRITE.
- IDLE with `start`=1 latches all request inputs, clears `count` and goes to READ (copy) or WRITE (fill).
- IDLE with `start`=1 and `len`=0: no memory access, `done` pulses next cycle, `count`=0.
- READ: `mem_addr`=src pointer, `mem_we`=0, then go to WRITE.
- WRITE: `mem_addr`=dst pointer, `mem_we`=1, and `mem_wdata`=`mem_rdata` (copy) or the latched `fill_val` (fill).
  - On the WRITE edge: increment both pointers and `count`, and decrement the remaining length.
  - If remaining length becomes 0, go to IDLE and pulse `done`.
  - Otherwise go to READ (copy) or stay in WRITE (fill).
- Addresses ascend and wrap from 0xFFFF to 0x0000.
- Copy is strictly forward. Overlap with dst > src propagates earlier bytes; this is the defined behaviour.
- `start` while busy is ignored.
- `abort`, sampled in READ or WRITE, wins over the current access completing. Next state is IDLE, no `done`, and `count` holds. An abort-cycle write still occurs because `mem_we` is already asserted.
- Outside READ/WRITE: `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.

## Timing
- Reset values: `busy`=0, `done`=0, `count`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, state IDLE.
- Reset mid-transfer stops immediately with no further writes.
- `busy`=1 from the cycle after the `start` edge through the final WRITE cycle.
- Copy takes 2·len access cycles. Fill takes len cycles.
- `done` is high for exactly one cycle, in the cycle after the final WRITE; `busy` is 0 in that cycle.
- A new `start` is accepted in the `done` cycle.
- `mem_addr` and `mem_we` are registered-state decodes. `mem_wdata` in copy is a combinational pass of `mem_rdata`. This is legal because the memory holds read data stable until its next read.

## Structure
- Shared package `mem_bus_pkg`: `mover_state_t` (IDLE/READ/WRITE), `mover_mode_t` (COPY/FILL), and the `ADDR_W`/`DATA_W` defaults.
- Single module; no sub-module is warranted.
- The bench pairs it with the existing 64 KiB test memory, driven from the same `clk`/`rst_b`.

## Test plan
- Fill: dst=0x0200, len=4, fill_val=0x5A → four consecutive write cycles; 0x0200–0x0203 = 0x5A; 0x0204 unchanged (0xFF); `done` at cycle 5; `count`=4.
- Copy: mem[0x1000..0x1002]=11,22,33; src=0x1000, dst=0x2000, len=3 → READ/WRITE alternating; 0x2000..0x2002 = 11,22,33; `done` at cycle 7.
- Overlap and wrap:
  - src=0x0010, dst=0x0011, len=4, mem[0x10]=0xAA → 0x11–0x14 all 0xAA.
  - fill dst=0xFFFE, len=4 → 0xFFFE, 0xFFFF, 0x0000, 0x0001 written.
- len=0 with `start` → no `mem_we`, `done` next cycle, `busy` never high. `start` pulses while busy → ignored; the original transfer completes unchanged.
- `abort` during the second WRITE of a len=8 fill → IDLE next cycle, no `done`, `count`=1, exactly 2 bytes written.
- `rst_b` asserted asynchronously mid-copy → outputs at reset values without waiting for a clock edge; after release, a new copy runs correctly.
